// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud-timing helpers.
// Used by the RX sequencer and its baud counter; the future TX block will import it as well.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Clocks per serial bit for a given system clock and bit rate.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Clocks from the start edge to the start-bit mid-sample.
   function automatic int unsigned half_bit(input int unsigned cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus between the line front-end / downstream decoder and the UART RX sequencer.
//   h2l       : one-cycle start-edge pulse from the edge detector
//   rx_in     : synchronized serial line
//   rx_data   : last good received byte
//   rx_valid  : one-cycle strobe, rx_data updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver not idle
// master = environment side, slave = receiver side.
interface uart_rx_ctrl_if;
   import uart_pkg::*;

   logic                 h2l;
   logic                 rx_in;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output h2l, rx_in,
      input  rx_data, rx_valid, frame_err, busy
   );

   modport slave (
      input  h2l, rx_in,
      output rx_data, rx_valid, frame_err, busy
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Clearable free-running bit-timing counter with a terminal-count compare.
//   clk, rst   : clock, synchronous active-low reset
//   clr_i      : force count to 0 on the next edge (priority over counting)
//   tc_val_i   : terminal-count compare value
//   tc_c_o     : combinational, high while count == tc_val_i
module uart_baud_cnt #(
   parameter int unsigned CNT_W = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic             tc_c_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst)       cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else            cnt_q <= cnt_q + CNT_W'(1);
   end

   assign tc_c_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive sequencer. Triggered by the start-edge pulse, samples the line at
// mid-bit, presents each good byte with a one-cycle rx_valid strobe and flags bad stop bits.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of uart_rx_ctrl_if (h2l/rx_in in; rx_data/rx_valid/frame_err/busy out)
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_ctrl_if.slave  bus
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF_BIT     = half_bit(CLKS_PER_BIT);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W        = $clog2(DATA_BITS);

   uart_state_e          state_q, state_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 busy_q, busy_d;

   logic                 cnt_clr_c;
   logic [CNT_W-1:0]     tc_val_c;
   logic                 tc_c;

   // Bit timing: START compares against the half-bit point, DATA/STOP against a full bit.
   uart_baud_cnt #(.CNT_W(CNT_W)) u_baud_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (cnt_clr_c),
      .tc_val_i (tc_val_c),
      .tc_c_o   (tc_c)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.h2l) state_d = START;
         START: if (tc_c) state_d = bus.rx_in ? IDLE : DATA;   // high at mid-start = false start
         DATA:  if (tc_c && (bit_idx_q == IDX_W'(DATA_BITS - 1))) state_d = STOP;
         STOP:  if (tc_c) state_d = IDLE;                       // leave at mid-stop-bit
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values and counter control.
   always_comb begin
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      cnt_clr_c   = 1'b0;
      tc_val_c    = CNT_W'(CLKS_PER_BIT - 1);
      case (state_q)
         IDLE: cnt_clr_c = 1'b1;   // counter sits at 0 so START begins counting from 0
         START: begin
            tc_val_c = CNT_W'(HALF_BIT - 1);
            if (tc_c) begin
               cnt_clr_c = 1'b1;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (tc_c) begin
               cnt_clr_c = 1'b1;
               shift_d   = {bus.rx_in, shift_q[DATA_BITS-1:1]};   // LSB first on the line
               bit_idx_d = bit_idx_q + IDX_W'(1);
            end
         end
         STOP: begin
            if (tc_c) begin
               cnt_clr_c = 1'b1;
               if (bus.rx_in) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: cnt_clr_c = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives 8N1 frames on the line with a start-edge pulse,
// queues the expected strobe for each frame, and a monitor compares strobes as they appear.
module tb_uart_rx_ctrl;

   localparam int unsigned CPB  = 16;                  // 160 Hz / 10 baud
   localparam int unsigned HALF = 8;
   localparam int          LAT  = HALF + 9 * CPB + 1;  // cycle index of the strobe after h2l (cycle 0)
   localparam int          FRAME_CYC = 10 * CPB;

   typedef struct {
      bit         ok;      // 1 = rx_valid expected, 0 = frame_err expected
      logic [7:0] data;    // rx_data expected while the strobe is high
      int         cyc;     // cycle counter value when the strobe is visible
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;
   logic [7:0] last_good;
   exp_t exp_q[$];

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(.CLK_FREQ(160), .BAUD(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc == n while the registers hold the values produced by edge n.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h) at cyc %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   // Monitor: every strobe must match the oldest pending expectation; overdue ones are misses.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (bus.rx_valid || bus.frame_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", int'({bus.rx_valid, bus.frame_err}), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("strobe_kind",  int'(bus.rx_valid), int'(e.ok));
               check("strobe_excl",  int'(bus.rx_valid & bus.frame_err), 0);
               check("strobe_data",  int'(bus.rx_data), int'(e.data));
               check("strobe_cycle", cyc, e.cyc);
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            check("missed_strobe", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   // Reference line model: start(0), 8 data bits LSB first, stop; one bit per CPB cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit extra_h2l);
      logic [9:0] bits;
      exp_t       e;
      int         h2l_edge;
      int         bad;
      bits     = {stop, b, 1'b0};
      h2l_edge = cyc + 1;
      if (stop) last_good = b;
      e.ok   = stop;
      e.data = last_good;
      e.cyc  = h2l_edge + LAT - 1;
      exp_q.push_back(e);
      bad = 0;
      for (int k = 0; k < FRAME_CYC; k++) begin
         bus.rx_in = bits[k / CPB];
         bus.h2l   = (k == 0) || (extra_h2l && (k == 40 || k == 100 || k == 150));
         @(negedge clk);
         if (bus.busy !== (k < LAT - 1)) bad++;
      end
      bus.h2l = 1'b0;
      check("busy_window", bad, 0);
   endtask

   task automatic idle_line(input int n);
      bus.rx_in = 1'b1;
      bus.h2l   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Start edge followed by a short low pulse: receiver must give up at the mid-start sample.
   task automatic glitch();
      for (int k = 0; k < 20; k++) begin
         bus.rx_in = (k < 3) ? 1'b0 : 1'b1;
         bus.h2l   = (k == 0);
         @(negedge clk);
         if (k == HALF - 1) check("glitch_busy_before", int'(bus.busy), 1);
         if (k == HALF)     check("glitch_busy_after",  int'(bus.busy), 0);
      end
      bus.h2l = 1'b0;
   endtask

   // Frame abandoned by reset during data bit 4.
   task automatic abort_frame(input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 5 * CPB + 5; k++) begin
         bus.rx_in = bits[k / CPB];
         bus.h2l   = (k == 0);
         @(negedge clk);
      end
      bus.h2l = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      check("abort_rx_data",   int'(bus.rx_data), 0);
      check("abort_rx_valid",  int'(bus.rx_valid), 0);
      check("abort_frame_err", int'(bus.frame_err), 0);
      check("abort_busy",      int'(bus.busy), 0);
      last_good = 8'h00;
      rst       = 1'b1;
      idle_line(10);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      last_good = 8'h00;
      rst       = 1'b0;
      bus.h2l   = 1'b0;
      bus.rx_in = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data",   int'(bus.rx_data), 0);
      check("reset_rx_valid",  int'(bus.rx_valid), 0);
      check("reset_frame_err", int'(bus.frame_err), 0);
      check("reset_busy",      int'(bus.busy), 0);
      rst = 1'b1;
      idle_line(5);

      send_frame(8'h55, 1'b1, 1'b0);
      idle_line(5);
      send_frame(8'hA3, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);      // back-to-back, minimum stop
      idle_line(5);
      glitch();
      check("glitch_rx_data", int'(bus.rx_data), 8'h0F);
      idle_line(5);
      send_frame(8'h00, 1'b0, 1'b0);      // bad stop bit
      idle_line(5);
      abort_frame(8'hC7);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle_line(5);
      send_frame(8'h96, 1'b1, 1'b1);      // extra start pulses mid-frame
      idle_line(5);

      for (int i = 0; i < 24; i++) begin
         logic [7:0] b;
         logic       s;
         bit         x;
         b = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 3) != 0);
         x = 1'($urandom_range(0, 1));
         send_frame(b, s, x);
         idle_line(int'($urandom_range(0, 12)));
      end

      idle_line(2 * FRAME_CYC);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive sequencer for the host-to-board serial link. It is triggered by the one-cycle falling-edge pulse (h2l) from the start-edge detector and samples the synchronized rx_in line at mid-bit. It assembles 8N1 frames and presents each byte with a one-cycle valid strobe to the music/command decoder downstream. It also flags false starts and framing errors.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, serial bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clocks per bit (derived, localparam)
HALF_BIT, CLKS_PER_BIT/2, clocks from h2l to the start-bit mid-sample (derived)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low
h2l  input  1  one-cycle start-edge pulse from the edge detector
rx_in  input  1  serial line, already double-registered (same stage that feeds the detector)
rx_data  output  8  last good received byte, LSB first on the line
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock. Reset is synchronous, active-low on rst. While rst=0: state=IDLE, cnt=0, bit_idx=0, shift=0, rx_data=8'h00, rx_valid=0, frame_err=0, busy=0. Reset mid-frame abandons the frame with no strobe.
- State machine: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE: h2l=1 -> START, cnt<=0. h2l is ignored in every other state.
- START: cnt increments each cycle. At cnt==HALF_BIT-1, sample rx_in:
  - 0 -> DATA, cnt<=0, bit_idx<=0.
  - 1 -> false start; return to IDLE with no strobe.
- DATA: at cnt==CLKS_PER_BIT-1, shift <= {rx_in, shift[7:1]}, cnt<=0, bit_idx++. The sample after bit_idx==7 -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_in:
  - 1 -> rx_data<=shift, rx_valid=1 for one cycle.
  - 0 -> frame_err=1 for one cycle; rx_data unchanged.
  - Either way -> IDLE.
  - STOP is left at mid-stop-bit, so a back-to-back frame's start edge is caught in IDLE.
- Latency: h2l seen at cycle 0 -> rx_valid high at cycle HALF_BIT+9*CLKS_PER_BIT+1.
- rx_data holds its value until the next good frame. rx_valid and frame_err are never high together.
- cnt width: $clog2(CLKS_PER_BIT). cnt saturates to 0 on every bit boundary and never wraps elsewhere.
- busy = (state != IDLE), registered with the state.
- rx_in glitches inside DATA are not filtered (single mid-bit sample).

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/STOP (2 bits)
  - DATA_BITS=8
  - the CLKS_PER_BIT / HALF_BIT derivation function
- One natural sub-module: uart_baud_cnt. It is a clearable counter with a terminal-count compare output that takes the compare value as an input, so START uses HALF_BIT-1 and DATA/STOP use CLKS_PER_BIT-1. It is reusable by the future TX block.

Test Plan:
Bench parameters: CLK_FREQ=160, BAUD=10 (CLKS_PER_BIT=16, HALF_BIT=8). Stimulus drives rx_in and an h2l pulse on the falling edge.
- Frame 0x55 (stop=1) -> rx_valid pulse at cycle 153 after h2l, rx_data=8'h55, frame_err=0, busy high cycles 1..152.
- Frame 0xA3 immediately followed by 0x0F (minimum stop) -> two rx_valid pulses, rx_data 8'hA3 then 8'h0F, no missed start.
- Glitch: rx_in low 3 cycles with h2l pulse, then high -> return to IDLE at cycle 9, no rx_valid, no frame_err, rx_data unchanged.
- Frame 0x00 with stop bit 0 -> frame_err pulse at cycle 153, rx_valid=0, rx_data keeps the previous value (8'h0F).
- rst=0 asserted during bit 4 of a frame -> next cycle all outputs at reset values. A following frame 0x3C receives correctly.
- Extra h2l pulses injected during DATA -> ignored; 0x96 received intact.
